shift_sched: RTL and testbench
==============================

Name: shift_sched

Overview:
- Shared multi-cycle 16-bit shift/rotate engine for two requesters, e.g. the execute-stage ALU port and a spare/debug port.
- Round-robin arbitration with valid/ready handshakes on both requester ports.
- Each accepted job is sequenced one barrel stage per cycle (1, 2, 4, 8 positions, selected by count bits 0..3).
- Result is returned on a valid/ready response port tagged with the requester id.

Parameters:
PRIO_INIT, 0, requester that wins the first contested arbitration after reset (0 or 1)

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  asynchronous reset, active-high
req0_valid  input  1  requester 0 has a job
req0_ready  output  1  requester 0 job accepted this cycle when high with req0_valid
req0_in  input  16  requester 0 operand
req0_cnt  input  4  requester 0 shift amount 0..15
req0_op  input  2  requester 0 op: 00 ROL, 01 SLL, 10 ROR, 11 SRA
req1_valid, req1_ready, req1_in, req1_cnt, req1_op  same as requester 0, for requester 1
rsp_valid  output  1  result available
rsp_ready  input  1  consumer takes result
rsp_data  output  16  shifted result
rsp_id  output  1  requester that issued the job
busy  output  1  high whenever state is not IDLE

Behaviour:
- Reset: state IDLE, rsp_valid=0, rsp_data=0, rsp_id=0, busy=0, stage counter=0, round-robin pointer favours PRIO_INIT.
- Reset is asynchronous and takes effect mid-job: the job is discarded and no response is produced.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - grant = the only valid requester; if both are valid, the favoured one.
  - reqN_ready = (state==IDLE) && grant==N. This is combinational from state and valids; valid must not depend on ready.
  - On accept (reqN_valid && reqN_ready): capture in/cnt/op/id into working registers, stage=0, state goes to SHIFT. The pointer now favours the other requester.
- SHIFT:
  - Each edge applies stage k=stage.
  - If cnt[k]=1, shift the working value by 2^k according to op; otherwise leave it unchanged.
  - SLL fills with 0. SRA fills with bit 15 of the current working value. ROL/ROR wrap bits around.
  - After stage 3 is applied, state goes to DONE and rsp_valid rises.
  - Fixed latency: rsp_valid is high from the 4th edge after the accept edge.
- DONE:
  - rsp_valid=1; rsp_data and rsp_id are held stable while rsp_ready=0.
  - On rsp_valid && rsp_ready, state goes to IDLE and rsp_valid drops.
  - Both ready outputs are low in SHIFT and DONE, so at least one IDLE cycle separates jobs.
- cnt=0: the value passes through unchanged with the same fixed latency.
- Requester inputs are ignored after acceptance; changing them mid-job has no effect.
- Composing stages gives an exact shift by cnt mod 16. cnt=15 ROR equals ROL by 1.

Optional Feature:
Macro SHIFT_SKIP_EN.
- Defined:
  - SHIFT visits only the stages whose cnt bit is set; each edge applies the next set bit.
  - rsp_valid rises popcount(cnt) edges after the accept edge.
  - cnt=0 goes IDLE to DONE directly on the accept edge, so rsp_valid is high in the following cycle.
- Undefined: fixed 4-stage latency as described under Behaviour.

Test Plan:
- req0 SRA in=0x8000 cnt=4 -> rsp_data=0xF800, rsp_id=0, rsp_valid 4 edges after accept (1 edge with SHIFT_SKIP_EN).
- req1 ROL in=0x8001 cnt=1 -> 0x0003. ROR in=0x0001 cnt=15 -> 0x0002. SLL in=0x00FF cnt=8 -> 0xFF00. cnt=0 -> input unchanged.
- req0 and req1 valid in the same cycle with PRIO_INIT=0 -> req0 granted first (rsp_id=0), then req1 (rsp_id=1). A third contested round goes to req0.
- rsp_ready held low 3 cycles in DONE -> rsp_valid/rsp_data/rsp_id stable, both reqN_ready=0. Release -> IDLE next edge, new accept possible.
- rst pulsed during SHIFT stage 2 -> busy=0, rsp_valid=0, rsp_data=0 immediately. No response for the aborted job; the next job completes normally.
- Change req0_in/cnt during SHIFT -> result reflects only the values captured at accept.

Source files
------------

// File: rtl/shift_sched.sv
// shift_sched: shared 16-bit shift/rotate engine, two round-robin requesters, one barrel stage per cycle.
// Optional macro SHIFT_SKIP_EN: visit only the stages whose count bit is set.
module shift_sched #(
   parameter int PRIO_INIT = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [15:0] req0_in,
   input  logic [3:0]  req0_cnt,
   input  logic [1:0]  req0_op,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [15:0] req1_in,
   input  logic [3:0]  req1_cnt,
   input  logic [1:0]  req1_op,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [15:0] rsp_data,
   output logic        rsp_id,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   localparam logic PRIO_RST = (PRIO_INIT != 0);

   state_t      state_q, state_d;
   logic [15:0] work_q, work_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [1:0]  op_q, op_d;
   logic [1:0]  stage_q, stage_d;
   logic        id_q, id_d;
   logic        prio_q, prio_d;

   logic        grant;
   logic        accept;
   logic [15:0] sel_in;
   logic [3:0]  sel_cnt;
   logic [1:0]  sel_op;

   // One barrel stage: shift by 2^k. Op encoding 00 ROL, 01 SLL, 10 ROR, 11 SRA.
   function automatic logic [15:0] stage_shift(input logic [15:0] v, input logic [1:0] op,
                                               input logic [1:0] k);
      logic [4:0]  s;
      logic [15:0] r;
      s = 5'd1 << k;
      case (op)
         2'b00:   r = (v << s) | (v >> (5'd16 - s));
         2'b01:   r = v << s;
         2'b10:   r = (v >> s) | (v << (5'd16 - s));
         default: r = 16'($signed(v) >>> s);
      endcase
      return r;
   endfunction

`ifdef SHIFT_SKIP_EN
   // Returns {found, index} of the lowest set count bit at or above 'from'.
   function automatic logic [2:0] next_set(input logic [3:0] c, input logic [2:0] from);
      logic [2:0] res;
      res = 3'b000;
      for (int i = 0; i < 4; i++) begin
         if (!res[2] && (i >= int'(from)) && c[i]) res = {1'b1, 2'(i)};
      end
      return res;
   endfunction

   logic [2:0] nxt;
`endif

   // Sole valid requester wins; a contested cycle goes to the favoured one.
   always_comb begin
      if (req0_valid && req1_valid) grant = prio_q;
      else                          grant = req1_valid;
   end

   assign req0_ready = (state_q == IDLE) && req0_valid && !grant;
   assign req1_ready = (state_q == IDLE) && req1_valid &&  grant;
   assign accept     = req0_ready || req1_ready;
   assign sel_in     = grant ? req1_in  : req0_in;
   assign sel_cnt    = grant ? req1_cnt : req0_cnt;
   assign sel_op     = grant ? req1_op  : req0_op;

   // NOTE: every variable gets its hold value first so no path leaves one unassigned (no latch).
   always_comb begin
      state_d = state_q;
      work_d  = work_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      stage_d = stage_q;
      id_d    = id_q;
      prio_d  = prio_q;
`ifdef SHIFT_SKIP_EN
      nxt     = 3'b000;
`endif
      case (state_q)
         IDLE: begin
            if (accept) begin
               work_d = sel_in;
               cnt_d  = sel_cnt;
               op_d   = sel_op;
               id_d   = grant;
               prio_d = !grant;
`ifdef SHIFT_SKIP_EN
               nxt = next_set(sel_cnt, 3'd0);
               if (nxt[2]) begin
                  stage_d = nxt[1:0];
                  state_d = SHIFT;
               end else begin
                  stage_d = 2'd0;
                  state_d = DONE;
               end
`else
               stage_d = 2'd0;
               state_d = SHIFT;
`endif
            end
         end
         SHIFT: begin
            if (cnt_q[stage_q]) work_d = stage_shift(work_q, op_q, stage_q);
`ifdef SHIFT_SKIP_EN
            nxt = next_set(cnt_q, {1'b0, stage_q} + 3'd1);
            if (nxt[2]) begin
               stage_d = nxt[1:0];
            end else begin
               stage_d = 2'd0;
               state_d = DONE;
            end
`else
            if (stage_q == 2'd3) begin
               stage_d = 2'd0;
               state_d = DONE;
            end else begin
               stage_d = stage_q + 2'd1;
            end
`endif
         end
         DONE: begin
            if (rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         work_q  <= 16'h0000;
         cnt_q   <= 4'h0;
         op_q    <= 2'b00;
         stage_q <= 2'd0;
         id_q    <= 1'b0;
         prio_q  <= PRIO_RST;
      end else begin
         state_q <= state_d;
         work_q  <= work_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         stage_q <= stage_d;
         id_q    <= id_d;
         prio_q  <= prio_d;
      end
   end

   assign rsp_valid = (state_q == DONE);
   assign rsp_data  = work_q;
   assign rsp_id    = id_q;
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_shift_sched.sv
// Self-checking bench for shift_sched: scoreboard of expected responses, one task per scenario.
module tb_shift_sched;

   logic        clk = 1'b0;
   logic        rst;
   logic        req0_valid, req0_ready, req1_valid, req1_ready;
   logic [15:0] req0_in, req1_in;
   logic [3:0]  req0_cnt, req1_cnt;
   logic [1:0]  req0_op, req1_op;
   logic        rsp_valid, rsp_ready, rsp_id, busy;
   logic [15:0] rsp_data;

   typedef struct packed {
      logic        id;
      logic [15:0] data;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   localparam logic [1:0] ROL = 2'b00, SLL = 2'b01, ROR = 2'b10, SRA = 2'b11;

   shift_sched #(.PRIO_INIT(0)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_in(req0_in),
      .req0_cnt(req0_cnt), .req0_op(req0_op),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_in(req1_in),
      .req1_cnt(req1_cnt), .req1_op(req1_op),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_id(rsp_id), .busy(busy)
   );

   always #5 clk = ~clk;

   // Reference: single-bit steps repeated cnt times.
   function automatic logic [15:0] model(input logic [15:0] v, input logic [3:0] c,
                                         input logic [1:0] op);
      logic [15:0] r;
      r = v;
      for (int i = 0; i < int'(c); i++) begin
         case (op)
            ROL:     r = {r[14:0], r[15]};
            SLL:     r = {r[14:0], 1'b0};
            ROR:     r = {r[0], r[15:1]};
            default: r = {r[15], r[15:1]};
         endcase
      end
      return r;
   endfunction

   function automatic int lat_of(input logic [3:0] c);
`ifdef SHIFT_SKIP_EN
      return $countones(c);
`else
      return (c == c) ? 4 : 4;
`endif
   endfunction

   task automatic drive(input logic id, input logic [15:0] din, input logic [3:0] c,
                        input logic [1:0] op);
      if (!id) begin
         req0_valid = 1'b1; req0_in = din; req0_cnt = c; req0_op = op;
      end else begin
         req1_valid = 1'b1; req1_in = din; req1_cnt = c; req1_op = op;
      end
   endtask

   // Called at a negedge with the request driven; returns at the negedge after the accept edge.
   task automatic wait_accept(input logic id);
      int n = 0;
      #1;
      while (!(id ? req1_ready : req0_ready) && n < 50) begin
         @(negedge clk); #1; n++;
      end
      checks++;
      if (!(id ? req1_ready : req0_ready)) begin
         errors++;
         $display("FAIL accept_req%0d: ready never rose within %0d cycles", id, n);
      end
      @(posedge clk);
      @(negedge clk);
      if (!id) req0_valid = 1'b0;
      else     req1_valid = 1'b0;
   endtask

   task automatic wait_valid(input int exp_lat);
      int lat = 0;
      while (!rsp_valid && lat < 20) begin
         @(negedge clk); lat++;
      end
      checks++;
      if (lat !== exp_lat) begin
         errors++;
         $display("FAIL latency: got %0d edges, expected %0d", lat, exp_lat);
      end
   endtask

   task automatic check_pop();
      exp_t e;
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $display("FAIL scoreboard: response with nothing expected (data %h)", rsp_data);
         return;
      end
      e = sb.pop_front();
      if (rsp_valid !== 1'b1 || rsp_data !== e.data || rsp_id !== e.id) begin
         errors++;
         $display("FAIL rsp: valid %b data %h id %b, expected valid 1 data %h id %b",
                  rsp_valid, rsp_data, rsp_id, e.data, e.id);
      end
   endtask

   task automatic consume();
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL consume: rsp_valid %b busy %b, expected 0 0", rsp_valid, busy);
      end
   endtask

   task automatic run_job(input logic id, input logic [15:0] din, input logic [3:0] c,
                          input logic [1:0] op);
      sb.push_back('{id: id, data: model(din, c, op)});
      drive(id, din, c, op);
      wait_accept(id);
      wait_valid(lat_of(c));
      check_pop();
      consume();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      req0_valid = 1'b0; req0_in = '0; req0_cnt = '0; req0_op = '0;
      req1_valid = 1'b0; req1_in = '0; req1_cnt = '0; req1_op = '0;
      rsp_ready = 1'b1;
      @(negedge clk); #1;
      checks++;
      if (busy !== 1'b0 || rsp_valid !== 1'b0 || rsp_data !== 16'h0 || rsp_id !== 1'b0 ||
          req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset: busy %b valid %b data %h id %b rdy %b%b, expected all zero",
                  busy, rsp_valid, rsp_data, rsp_id, req0_ready, req1_ready);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_ops();
      run_job(1'b0, 16'h8000, 4'd4,  SRA);
      run_job(1'b1, 16'h8001, 4'd1,  ROL);
      run_job(1'b1, 16'h0001, 4'd15, ROR);
      run_job(1'b1, 16'h00FF, 4'd8,  SLL);
      run_job(1'b1, 16'hBEEF, 4'd0,  SRA);
      run_job(1'b0, 16'h1234, 4'd0,  ROL);
      run_job(1'b0, 16'h7FF0, 4'd11, SRA);
      run_job(1'b1, 16'hC3A5, 4'd13, ROL);
      run_job(1'b0, 16'hFFFF, 4'd15, SLL);
      run_job(1'b1, 16'h8421, 4'd6,  ROR);
   endtask

   task automatic test_arbitration();
      for (int round = 0; round < 2; round++) begin
         sb.push_back('{id: 1'b0, data: model(16'h0F00, 4'd2, SLL)});
         drive(1'b0, 16'h0F00, 4'd2, SLL);
         drive(1'b1, 16'h00F0, 4'd3, ROR);
         #1;
         checks++;
         if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL arb_round%0d: ready0 %b ready1 %b, expected 1 0",
                     round, req0_ready, req1_ready);
         end
         wait_accept(1'b0);
         wait_valid(lat_of(4'd2));
         check_pop();
         consume();
         sb.push_back('{id: 1'b1, data: model(16'h00F0, 4'd3, ROR)});
         wait_accept(1'b1);
         wait_valid(lat_of(4'd3));
         check_pop();
         consume();
      end
   endtask

   task automatic test_backpressure();
      exp_t e;
      e = '{id: 1'b1, data: model(16'h1234, 4'd3, ROL)};
      rsp_ready = 1'b0;
      sb.push_back(e);
      drive(1'b1, 16'h1234, 4'd3, ROL);
      wait_accept(1'b1);
      wait_valid(lat_of(4'd3));
      check_pop();
      drive(1'b0, 16'h0F0F, 4'd9, SRA);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); #1;
         checks++;
         if (rsp_valid !== 1'b1 || rsp_data !== e.data || rsp_id !== e.id ||
             req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL hold%0d: valid %b data %h id %b rdy %b%b, expected 1 %h %b 00",
                     i, rsp_valid, rsp_data, rsp_id, req0_ready, req1_ready, e.data, e.id);
         end
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk); #1;
      checks++;
      if (rsp_valid !== 1'b0 || req0_ready !== 1'b1) begin
         errors++;
         $display("FAIL release: rsp_valid %b req0_ready %b, expected 0 1", rsp_valid, req0_ready);
      end
      sb.push_back('{id: 1'b0, data: model(16'h0F0F, 4'd9, SRA)});
      wait_accept(1'b0);
      wait_valid(lat_of(4'd9));
      check_pop();
      consume();
   endtask

   task automatic test_reset_midjob();
      int seen = 0;
      drive(1'b0, 16'hA5A5, 4'hF, SRA);
      wait_accept(1'b0);
      @(negedge clk);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      checks++;
      if (busy !== 1'b0 || rsp_valid !== 1'b0 || rsp_data !== 16'h0) begin
         errors++;
         $display("FAIL abort: busy %b valid %b data %h, expected 0 0 0000", busy, rsp_valid, rsp_data);
      end
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (rsp_valid) seen++;
      end
      checks++;
      if (seen != 0) begin
         errors++;
         $display("FAIL abort_rsp: rsp_valid seen %0d cycles, expected 0", seen);
      end
      run_job(1'b1, 16'h3C3C, 4'd5, ROL);
   endtask

   task automatic test_input_change();
      sb.push_back('{id: 1'b0, data: model(16'h0F0F, 4'd5, ROR)});
      drive(1'b0, 16'h0F0F, 4'd5, ROR);
      wait_accept(1'b0);
      req0_in = 16'hFFFF; req0_cnt = 4'd1; req0_op = SLL;
      req1_in = 16'h5555; req1_cnt = 4'd7; req1_op = SRA;
      wait_valid(lat_of(4'd5));
      check_pop();
      consume();
   endtask

   initial begin
      test_reset();
      test_ops();
      test_arbitration();
      test_backpressure();
      test_reset_midjob();
      test_input_change();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL leftover: %0d expected responses never produced", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
